muldiv_seq: RTL and testbench

//  Multi-cycle multiply/divide sequencer, companion to the single-cycle ALU in EXE.

---
 rtl/muldiv_seq_pkg.sv | 26 ++
 rtl/muldiv_seq_addsub.sv | 20 ++
 rtl/muldiv_seq.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared op/state encodings for the multi-cycle multiply/divide sequencer.
// Helpers decode the op into divide and signed flavours.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_CALC  = 2'b01,
        MD_FIXUP = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq_addsub.sv
// WIDTH+1 add/subtract with carry-out, shared by the multiply and divide paths.
// Combinational; in subtract mode cout=1 means x >= y (no borrow).
module muldiv_seq_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           cout
);

    logic [WIDTH+1:0] full;
    logic [WIDTH:0]   y_eff;

    assign y_eff       = sub ? ~y : y;
    assign full        = {1'b0, x} + {1'b0, y_eff} + {{(WIDTH+1){1'b0}}, sub};
    assign {cout, sum} = full;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU, 1 bit per cycle; done pulses WIDTH+2 cycles after start.
// start is ignored while busy; cancel aborts the op in flight and leaves hi/lo untouched.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand magnitudes, computed from the live inputs for the latch edge.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = op_is_signed(op) & a[WIDTH-1];
    assign b_neg = op_is_signed(op) & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [WIDTH:0] as_x, as_y, as_sum;
    logic           as_sub, as_cout;

    // Divide: rem_q already holds the partial remainder with the next dividend bit shifted in.
    assign as_sub = is_div_q;
    assign as_x   = is_div_q ? rem_q : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign as_y   = (is_div_q || acc_q[0]) ? {1'b0, opnd_q} : '0;

    muldiv_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x    (as_x),
        .y    (as_y),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, rem_part;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        rem_part = as_cout ? as_sum[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            MD_IDLE: begin
                if (start && !cancel) begin
                    state_d  = MD_CALC;
                    cnt_d    = '0;
                    is_div_d = op_is_div(op);
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    b_zero_d = (b == '0);
                    if (op_is_div(op)) begin
                        opnd_d = b_mag;
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        rem_d  = {{WIDTH{1'b0}}, a_mag[WIDTH-1]};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        rem_d  = '0;
                    end
                end
            end
            MD_CALC: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], as_cout};
                        // Last step parks the final remainder instead of pulling another bit.
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            rem_d = {1'b0, rem_part};
                        end else begin
                            rem_d = {rem_part, acc_q[WIDTH-2]};
                        end
                    end else begin
                        acc_d = {as_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = MD_FIXUP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MD_FIXUP: begin
                state_d = MD_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        // With a zero divisor the remainder path reconstructs the raw dividend.
                        hi_d = rem_fix;
                        lo_d = b_zero_q ? '1 : quo_fix;
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: inputs change on negedge, outputs sampled on negedge.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drives start during cycle 0; returns at the negedge of cycle 1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        start_op(o, x, y);
        check({tag, "_busy1"}, 64'(busy), 64'd1);
        wait_done(1, cyc);
        check({tag, "_lat"}, 64'(cyc), 64'd34);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int done_seen;
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = MD_MULTU;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg", MD_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_min", MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", MD_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_5_2", MD_DIVU, 32'd5, 32'd2, 32'd1, 32'd2);

        // Cancel in cycle 10 of a DIVU: no done, previous hi/lo kept.
        start_op(MD_DIVU, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("cancel_nodone", 64'(done_seen), 64'd0);
        check("cancel_hi", 64'(hi), 64'd1);
        check("cancel_lo", 64'(lo), 64'd2);

        // start together with cancel in IDLE is dropped.
        op = MD_MULTU; a = 32'd9; b = 32'd9;
        start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_busy", 64'(busy), 64'd0);

        // start while busy is ignored; start in the done cycle is taken.
        start_op(MD_MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        start_op(MD_DIVU, 32'd100, 32'd3);
        wait_done(6, cyc);
        check("ign_lat", 64'(cyc), 64'd34);
        check("ign_hi", 64'(hi), 64'd0);
        check("ign_lo", 64'(lo), 64'd42);
        start_op(MD_DIVU, 32'd100, 32'd7);
        wait_done(1, cyc);
        check("b2b_lat", 64'(cyc), 64'd34);
        check("b2b_hi", 64'(hi), 64'd2);
        check("b2b_lo", 64'(lo), 64'd14);
        @(negedge clk);

        // Asynchronous reset between edges in mid-CALC.
        start_op(MD_MULTU, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst", MD_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
